ex_operand_forward_unit: RTL and testbench
==========================================

// Module: ex_operand_forward_unit
// PURPOSE
//  EX-stage operand front end for the 5-stage pipeline: holds the ID/EX operand register, resolves
//  EX/MEM and MEM/WB forwarding for both ALU operands, applies imm/PC source select after forwarding,
//  and runs the load-use interlock FSM that stalls IF/ID and injects bubbles.
//  Successor to the single-operand src2 mux: both operands, WB->ID bypass, parametrised load latency.
// PARAMETERS
//  XLEN      32  datapath width
//  RA_W       5  register address width; register 0 is hardwired zero
//  LOAD_LAT   1  bubbles inserted per load-use hazard (>=1)
// PORTS
//  clk              in   1     clock, rising edge
//  rst_n            in   1     asynchronous active-low reset
//  id_valid         in   1     ID holds a real instruction
//  id_rs1/id_rs2    in   RA_W  source register addresses
//  id_use_rs1/rs2   in   1     instruction actually reads rs1/rs2
//  id_rd            in   RA_W  destination register
//  id_rs1_data      in   XLEN  register file read data, port 1
//  id_rs2_data      in   XLEN  register file read data, port 2
//  id_imm, id_pc    in   XLEN  immediate, instruction PC
//  id_alu_src       in   1     1: alu_in2 = imm
//  id_src1_pc       in   1     1: alu_in1 = pc
//  id_reg_write     in   1     writes rd
//  id_mem_read      in   1     is a load
//  flush            in   1     branch/jump redirect: kill ID->EX transfer
//  mem_rd, mem_reg_write, mem_result   in  RA_W,1,XLEN  EX/MEM producer
//  wb_rd, wb_reg_write, wb_data        in  RA_W,1,XLEN  MEM/WB producer
//  stall_if_id      out  1     hold PC and IF/ID register
//  ex_valid, ex_rd, ex_reg_write, ex_mem_read  out 1,RA_W,1,1  registered ID/EX control
//  alu_in1, alu_in2 out  XLEN  final ALU operands (combinational from ID/EX regs + bypass)
//  store_data       out  XLEN  forwarded rs2 value, independent of id_alu_src
//  fwd_a, fwd_b     out  2     00 regfile, 01 MEM/WB, 10 EX/MEM
// BEHAVIOUR
//  Reset: all ID/EX registers 0, ex_valid=0, FSM=IDLE, cnt=0, stall_if_id=0.
//  hazard = id_valid & ex_valid & ex_mem_read & ex_rd!=0 &
//           ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  FSM IDLE: stall_if_id = hazard; if hazard & !flush -> STALL, cnt=LOAD_LAT-1 (LOAD_LAT=1: stay IDLE).
//  FSM STALL: stall_if_id=1; cnt decrements; at cnt==0 stall drops next cycle -> IDLE.
//  flush wins over everything: FSM->IDLE, cnt=0, stall_if_id=0 from next edge, bubble captured.
//  ID/EX capture each edge: flush | stall_if_id -> ex_valid=0, ex_reg_write=0, ex_mem_read=0
//   (data regs don't-care); else capture all id_* fields, ex_valid=id_valid.
//  WB->ID bypass at capture: if wb_reg_write & wb_rd!=0 & wb_rd==id_rsN, captured data = wb_data.
//  Forwarding (per operand N, against ex_rsN): EX/MEM match (mem_reg_write, mem_rd!=0, equal) -> 10;
//   else MEM/WB match -> 01; else 00. EX/MEM has priority. Register 0 never forwards.
//  alu_in1 = ex_src1_pc ? ex_pc : fwdA_val; alu_in2 = ex_alu_src ? ex_imm : fwdB_val;
//   store_data = fwdB_val. Forwarding never overrides imm/pc selection.
//  Latency: ID->EX one cycle; operands valid same cycle as ex_valid. No arithmetic; widths pass-through.
//  Reset asserted mid-stall: immediate return to IDLE, stall_if_id=0.
// TESTING
//  add x3 then sub x4,x3,x1 back-to-back, mem_result=0x55 -> fwd_a=10, alu_in1=0x55, no stall.
//  x3 in both EX/MEM(0xAA) and MEM/WB(0xBB) -> fwd=10, value 0xAA; rd=x0 producer -> fwd=00.
//  lw x5 then add x6,x5,x5, LOAD_LAT=1 -> stall 1 cycle, 1 bubble, then fwd=01 from wb_data.
//  LOAD_LAT=3 same sequence -> stall_if_id high 3 cycles, 3 bubbles; flush in cycle 2 -> stall drops.
//  sw x7 imm=0x10 with x7 forwarded 0x1234 -> alu_in2=0x10, store_data=0x1234.
//  wb writes x9=0xCAFE while ID reads x9 -> captured rs data 0xCAFE; rst_n low mid-stall -> all 0.

Source files
------------

// File: rtl/ex_operand_forward_if.sv
// ex_operand_forward_if: ID/EX operand-path bus between the pipeline and the EX operand front end.
//  id_*            ID-stage instruction fields and register file read data
//  flush           branch/jump redirect
//  mem_* / wb_*    EX/MEM and MEM/WB producers used for forwarding and WB->ID bypass
//  stall_if_id     load-use interlock back to IF/ID
//  ex_*            registered ID/EX control
//  alu_in1/2, store_data, fwd_a/b   resolved EX operands and forwarding selects
interface ex_operand_forward_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic id_valid, id_use_rs1, id_use_rs2, id_alu_src, id_src1_pc, id_reg_write, id_mem_read, flush;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, id_pc, mem_result, wb_data;
  logic [XLEN-1:0] alu_in1, alu_in2, store_data;
  logic mem_reg_write, wb_reg_write, stall_if_id, ex_valid, ex_reg_write, ex_mem_read;
  logic [1:0] fwd_a, fwd_b;
  modport master (
    output id_valid, id_use_rs1, id_use_rs2, id_alu_src, id_src1_pc, id_reg_write, id_mem_read, flush,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
    input  stall_if_id, ex_valid, ex_rd, ex_reg_write, ex_mem_read, alu_in1, alu_in2, store_data,
           fwd_a, fwd_b
  );
  modport slave (
    input  id_valid, id_use_rs1, id_use_rs2, id_alu_src, id_src1_pc, id_reg_write, id_mem_read, flush,
           id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_pc,
           mem_rd, mem_reg_write, mem_result, wb_rd, wb_reg_write, wb_data,
    output stall_if_id, ex_valid, ex_rd, ex_reg_write, ex_mem_read, alu_in1, alu_in2, store_data,
           fwd_a, fwd_b
  );
endinterface

// File: rtl/ex_operand_forward_unit.sv
// ex_operand_forward_unit: ID/EX operand register, two-operand EX/MEM+MEM/WB forwarding, load-use interlock.
//  clk, rst_n   clock (rising edge), asynchronous active-low reset
//  bus          ex_operand_forward_if.slave: ID fields, producers and flush in; stall, ex_* and operands out
module ex_operand_forward_unit #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int LOAD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  ex_operand_forward_if.slave bus
);
  localparam int CW = LOAD_LAT > 1 ? $clog2(LOAD_LAT) : 1;
  typedef enum logic {IDLE, STALL} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_alu_src, ex_src1_pc, hazard, stall, kill;
  logic [RA_W-1:0] ex_rd, ex_rs1, ex_rs2;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc, rs1_cap, rs2_cap, fwd_a_val, fwd_b_val;
  logic [1:0] fwd_a, fwd_b;
  assign hazard = bus.id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                  ((bus.id_use_rs1 & (bus.id_rs1 == ex_rd)) | (bus.id_use_rs2 & (bus.id_rs2 == ex_rd)));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  // The cycle that detects the hazard is the first stall cycle, so STALL covers the remaining LOAD_LAT-1.
  always_comb begin
    stall = (state == STALL) | hazard;
    state_nxt = state;
    cnt_nxt = cnt;
    if (bus.flush) begin
      state_nxt = IDLE;
      cnt_nxt = '0;
    end else if (state == IDLE && hazard && LOAD_LAT > 1) begin
      state_nxt = STALL;
      cnt_nxt = CW'(LOAD_LAT - 1);
    end else if (state == STALL) begin
      cnt_nxt = cnt - CW'(1);
      state_nxt = (cnt == CW'(1)) ? IDLE : STALL;
    end
  end
  // A write-back in the same cycle as the register file read is not yet visible in id_rsN_data.
  assign rs1_cap = (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs1) ? bus.wb_data : bus.id_rs1_data;
  assign rs2_cap = (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == bus.id_rs2) ? bus.wb_data : bus.id_rs2_data;
  assign kill = bus.flush | stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_alu_src <= 1'b0;
      ex_src1_pc <= 1'b0;
      ex_rd <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm <= '0;
      ex_pc <= '0;
    end else begin
      ex_valid <= ~kill & bus.id_valid;
      ex_reg_write <= ~kill & bus.id_reg_write;
      ex_mem_read <= ~kill & bus.id_mem_read;
      ex_alu_src <= bus.id_alu_src;
      ex_src1_pc <= bus.id_src1_pc;
      ex_rd <= bus.id_rd;
      ex_rs1 <= bus.id_rs1;
      ex_rs2 <= bus.id_rs2;
      ex_rs1_data <= rs1_cap;
      ex_rs2_data <= rs2_cap;
      ex_imm <= bus.id_imm;
      ex_pc <= bus.id_pc;
    end
  assign fwd_a = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == ex_rs1) ? 2'b10 :
                 (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == ex_rs1) ? 2'b01 : 2'b00;
  assign fwd_b = (bus.mem_reg_write && bus.mem_rd != '0 && bus.mem_rd == ex_rs2) ? 2'b10 :
                 (bus.wb_reg_write && bus.wb_rd != '0 && bus.wb_rd == ex_rs2) ? 2'b01 : 2'b00;
  assign fwd_a_val = fwd_a[1] ? bus.mem_result : fwd_a[0] ? bus.wb_data : ex_rs1_data;
  assign fwd_b_val = fwd_b[1] ? bus.mem_result : fwd_b[0] ? bus.wb_data : ex_rs2_data;
  assign bus.alu_in1 = ex_src1_pc ? ex_pc : fwd_a_val;
  assign bus.alu_in2 = ex_alu_src ? ex_imm : fwd_b_val;
  assign bus.store_data = fwd_b_val;
  assign bus.fwd_a = fwd_a;
  assign bus.fwd_b = fwd_b;
  assign bus.stall_if_id = stall;
  assign bus.ex_valid = ex_valid;
  assign bus.ex_rd = ex_rd;
  assign bus.ex_reg_write = ex_reg_write;
  assign bus.ex_mem_read = ex_mem_read;
endmodule

// File: tb/tb_ex_operand_forward_unit.sv
// tb_ex_operand_forward_unit: directed bench for forwarding, bypass and load-use interlock (LOAD_LAT 1 and 3).
module tb_ex_operand_forward_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  ex_operand_forward_if b1 ();
  ex_operand_forward_if b3 ();
  assign b3.id_valid = b1.id_valid;
  assign b3.id_use_rs1 = b1.id_use_rs1;
  assign b3.id_use_rs2 = b1.id_use_rs2;
  assign b3.id_alu_src = b1.id_alu_src;
  assign b3.id_src1_pc = b1.id_src1_pc;
  assign b3.id_reg_write = b1.id_reg_write;
  assign b3.id_mem_read = b1.id_mem_read;
  assign b3.flush = b1.flush;
  assign b3.id_rs1 = b1.id_rs1;
  assign b3.id_rs2 = b1.id_rs2;
  assign b3.id_rd = b1.id_rd;
  assign b3.id_rs1_data = b1.id_rs1_data;
  assign b3.id_rs2_data = b1.id_rs2_data;
  assign b3.id_imm = b1.id_imm;
  assign b3.id_pc = b1.id_pc;
  assign b3.mem_rd = b1.mem_rd;
  assign b3.mem_reg_write = b1.mem_reg_write;
  assign b3.mem_result = b1.mem_result;
  assign b3.wb_rd = b1.wb_rd;
  assign b3.wb_reg_write = b1.wb_reg_write;
  assign b3.wb_data = b1.wb_data;
  ex_operand_forward_unit #(.LOAD_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  ex_operand_forward_unit #(.LOAD_LAT(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear;
    b1.id_valid = 0; b1.id_use_rs1 = 0; b1.id_use_rs2 = 0; b1.id_alu_src = 0; b1.id_src1_pc = 0;
    b1.id_reg_write = 0; b1.id_mem_read = 0; b1.flush = 0; b1.id_rs1 = 0; b1.id_rs2 = 0; b1.id_rd = 0;
    b1.id_rs1_data = 0; b1.id_rs2_data = 0; b1.id_imm = 0; b1.id_pc = 0;
    b1.mem_rd = 0; b1.mem_reg_write = 0; b1.mem_result = 0; b1.wb_rd = 0; b1.wb_reg_write = 0; b1.wb_data = 0;
  endtask
  task automatic instr(input logic [4:0] rs1, rs2, rd, input logic use1, use2, rw, mr,
                       input logic [31:0] d1, d2);
    b1.id_valid = 1; b1.id_rs1 = rs1; b1.id_rs2 = rs2; b1.id_rd = rd; b1.id_use_rs1 = use1;
    b1.id_use_rs2 = use2; b1.id_reg_write = rw; b1.id_mem_read = mr; b1.id_rs1_data = d1; b1.id_rs2_data = d2;
  endtask
  initial begin
    clear();
    #12;
    chk("rst_ex_valid", 32'(b1.ex_valid), 0);
    chk("rst_stall", 32'(b1.stall_if_id), 0);
    chk("rst_alu_in1", b1.alu_in1, 0);
    chk("rst_fwd_a", 32'(b1.fwd_a), 0);
    chk("rst_stall3", 32'(b3.stall_if_id), 0);
    rst_n = 1;
    instr(3, 1, 4, 1, 1, 1, 0, 32'h11, 32'h22);
    #1 chk("exmem_nostall", 32'(b1.stall_if_id), 0);
    tick();
    clear();
    b1.mem_rd = 3; b1.mem_reg_write = 1; b1.mem_result = 32'h55;
    #1;
    chk("exmem_ex_valid", 32'(b1.ex_valid), 1);
    chk("exmem_ex_rd", 32'(b1.ex_rd), 4);
    chk("exmem_fwd_a", 32'(b1.fwd_a), 2);
    chk("exmem_alu_in1", b1.alu_in1, 32'h55);
    chk("exmem_fwd_b", 32'(b1.fwd_b), 0);
    chk("exmem_alu_in2", b1.alu_in2, 32'h22);
    b1.mem_result = 32'hAA; b1.wb_rd = 3; b1.wb_reg_write = 1; b1.wb_data = 32'hBB;
    #1;
    chk("prio_fwd_a", 32'(b1.fwd_a), 2);
    chk("prio_alu_in1", b1.alu_in1, 32'hAA);
    b1.mem_reg_write = 0;
    #1;
    chk("memwb_fwd_a", 32'(b1.fwd_a), 1);
    chk("memwb_alu_in1", b1.alu_in1, 32'hBB);
    clear();
    instr(0, 0, 8, 1, 1, 1, 0, 0, 0);
    tick();
    clear();
    b1.mem_rd = 0; b1.mem_reg_write = 1; b1.mem_result = 32'hAA;
    b1.wb_rd = 0; b1.wb_reg_write = 1; b1.wb_data = 32'hBB;
    #1;
    chk("x0_fwd_a", 32'(b1.fwd_a), 0);
    chk("x0_fwd_b", 32'(b1.fwd_b), 0);
    chk("x0_alu_in1", b1.alu_in1, 0);
    clear();
    instr(2, 0, 5, 1, 0, 1, 1, 32'h100, 0);
    tick();
    clear();
    instr(5, 5, 6, 1, 1, 1, 0, 0, 0);
    #1;
    chk("lu_stall1", 32'(b1.stall_if_id), 1);
    chk("lu_stall3_c0", 32'(b3.stall_if_id), 1);
    tick();
    chk("lu_bubble1", 32'(b1.ex_valid), 0);
    chk("lu_stall1_drop", 32'(b1.stall_if_id), 0);
    chk("lu_stall3_c1", 32'(b3.stall_if_id), 1);
    chk("lu_bubble3_c1", 32'(b3.ex_valid), 0);
    tick();
    b1.wb_rd = 5; b1.wb_reg_write = 1; b1.wb_data = 32'h77;
    #1;
    chk("lu_ex_valid1", 32'(b1.ex_valid), 1);
    chk("lu_ex_rd1", 32'(b1.ex_rd), 6);
    chk("lu_fwd_a", 32'(b1.fwd_a), 1);
    chk("lu_fwd_b", 32'(b1.fwd_b), 1);
    chk("lu_alu_in1", b1.alu_in1, 32'h77);
    chk("lu_alu_in2", b1.alu_in2, 32'h77);
    chk("lu_stall3_c2", 32'(b3.stall_if_id), 1);
    chk("lu_bubble3_c2", 32'(b3.ex_valid), 0);
    tick();
    b1.wb_reg_write = 0;
    #1;
    chk("lu_stall3_c3", 32'(b3.stall_if_id), 0);
    chk("lu_bubble3_c3", 32'(b3.ex_valid), 0);
    tick();
    chk("lu_ex_valid3", 32'(b3.ex_valid), 1);
    chk("lu_ex_rd3", 32'(b3.ex_rd), 6);
    clear();
    instr(2, 0, 5, 1, 0, 1, 1, 0, 0);
    tick();
    clear();
    instr(5, 5, 6, 1, 1, 1, 0, 0, 0);
    tick();
    b1.flush = 1;
    #1 chk("fl_stall3_during", 32'(b3.stall_if_id), 1);
    tick();
    b1.flush = 0;
    #1;
    chk("fl_stall3_after", 32'(b3.stall_if_id), 0);
    chk("fl_bubble3", 32'(b3.ex_valid), 0);
    chk("fl_kill1", 32'(b1.ex_valid), 0);
    clear();
    instr(2, 0, 5, 1, 0, 1, 1, 0, 0);
    tick();
    clear();
    instr(5, 5, 6, 1, 1, 1, 0, 32'h33, 32'h44);
    tick();
    chk("rs_stall3_pre", 32'(b3.stall_if_id), 1);
    rst_n = 0;
    #1;
    chk("rs_stall3", 32'(b3.stall_if_id), 0);
    chk("rs_ex_valid3", 32'(b3.ex_valid), 0);
    chk("rs_ex_rd3", 32'(b3.ex_rd), 0);
    chk("rs_alu_in1_3", b3.alu_in1, 0);
    rst_n = 1;
    tick();
    clear();
    instr(7, 7, 0, 1, 1, 0, 0, 32'h1, 32'h2);
    b1.id_imm = 32'h10; b1.id_alu_src = 1; b1.id_pc = 32'h400; b1.id_src1_pc = 1;
    tick();
    clear();
    b1.mem_rd = 7; b1.mem_reg_write = 1; b1.mem_result = 32'h1234;
    #1;
    chk("sw_fwd_b", 32'(b1.fwd_b), 2);
    chk("sw_alu_in2", b1.alu_in2, 32'h10);
    chk("sw_store_data", b1.store_data, 32'h1234);
    chk("sw_fwd_a", 32'(b1.fwd_a), 2);
    chk("sw_alu_in1_pc", b1.alu_in1, 32'h400);
    clear();
    instr(9, 9, 10, 1, 1, 1, 0, 32'h1, 32'h2);
    b1.wb_rd = 9; b1.wb_reg_write = 1; b1.wb_data = 32'hCAFE;
    tick();
    clear();
    #1;
    chk("byp_alu_in1", b1.alu_in1, 32'hCAFE);
    chk("byp_store_data", b1.store_data, 32'hCAFE);
    chk("byp_fwd_a", 32'(b1.fwd_a), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
